// File: rtl/dma_axi_write_slave.sv
// AXI4 write-only slave that turns single-outstanding INCR/FIXED bursts into
// one-cycle word writes on a simple memory port, with a sticky SLVERR response.
module dma_axi_write_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = '0,
  parameter int                    MEM_WORDS  = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
  input  logic [7:0]                   s_axi_awlen,
  input  logic [2:0]                   s_axi_awsize,
  input  logic [1:0]                   s_axi_awburst,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [31:0]                  s_axi_wdata,
  input  logic [3:0]                   s_axi_wstrb,
  input  logic                         s_axi_wlast,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  output logic                         o_mem_we,
  output logic [$clog2(MEM_WORDS)-1:0] o_mem_addr,
  output logic [31:0]                  o_mem_wdata,
  output logic [3:0]                   o_mem_wstrb
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  // Window bounds carry one extra bit so a window ending at the top of the
  // address space, or an INCR burst running past it, never wraps.
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, MEM_BASE};
  localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH+1)'(4 * MEM_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            r_state;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic [ADDR_WIDTH:0]   r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic                  r_incr;
  logic                  r_cfg_bad;
  logic                  r_err;
  logic                  r_mem_we;
  logic [IDX_W-1:0]      r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic [3:0]            r_mem_wstrb;

  logic                  w_beat;
  logic                  w_final;
  logic                  w_in_range;
  logic                  w_beat_err;
  logic                  w_err_next;
  logic                  w_aw_legal;
  logic [ADDR_WIDTH:0]   w_offset;
  logic [IDX_W-1:0]      w_mem_idx;

  assign w_beat     = (r_state == S_DATA) && r_wready && s_axi_wvalid;
  assign w_final    = (r_cnt == r_len);
  assign w_in_range = (r_addr >= WIN_LO) && (r_addr < WIN_HI);
  // A beat is also in error when wlast disagrees with the beat count.
  assign w_beat_err = !w_in_range || (s_axi_wlast != w_final);
  assign w_err_next = r_err || w_beat_err;
  assign w_aw_legal = (s_axi_awsize == 3'b010) && !s_axi_awburst[1];
  assign w_offset   = r_addr - WIN_LO;
  assign w_mem_idx  = IDX_W'(w_offset >> 2);

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values of all others.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bresp     <= 2'b00;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_incr      <= 1'b0;
      r_cfg_bad   <= 1'b0;
      r_err       <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_awready <= 1'b1;
          if (r_awready && s_axi_awvalid) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_state   <= S_DATA;
            r_addr    <= {1'b0, s_axi_awaddr & ~ADDR_WIDTH'(3)};
            r_len     <= s_axi_awlen;
            r_cnt     <= 8'd0;
            r_incr    <= (s_axi_awburst == 2'b01);
            r_cfg_bad <= !w_aw_legal;
            r_err     <= !w_aw_legal;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            r_cnt <= r_cnt + 8'd1;
            r_err <= w_err_next;
            if (r_incr) r_addr <= r_addr + (ADDR_WIDTH+1)'(4);
            if (!r_cfg_bad && w_in_range) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= w_mem_idx;
              r_mem_wdata <= s_axi_wdata;
              r_mem_wstrb <= s_axi_wstrb;
            end
            // Count-based termination: wlast never ends the burst early.
            if (w_final) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= w_err_next ? 2'b10 : 2'b00;
              r_state  <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (s_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_awready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_mem_wstrb   = r_mem_wstrb;

endmodule

// File: doc/dma_axi_write_slave.md
DMA_AXI_WRITE_SLAVE -- requirements
Module: dma_axi_write_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 Parameter MEM_BASE, default 32'h0000_0000, byte base address of the memory window.
REQ-003 Parameter MEM_WORDS, default 1024, window size in 32-bit words; SHALL be a power of 2.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 s_axi_awaddr  in  ADDR_WIDTH  burst start byte address.
REQ-007 s_axi_awlen  in  8  beats minus one.
REQ-008 s_axi_awsize  in  3  beat size; only 3'b010 is legal.
REQ-009 s_axi_awburst  in  2  burst type: 00 FIXED, 01 INCR; others illegal.
REQ-010 s_axi_awvalid / s_axi_awready  in / out  1  AW handshake.
REQ-011 s_axi_wdata  in  32  beat data.
REQ-012 s_axi_wstrb  in  4  byte enables.
REQ-013 s_axi_wlast  in  1  final-beat marker.
REQ-014 s_axi_wvalid / s_axi_wready  in / out  1  W handshake.
REQ-015 s_axi_bresp  out  2  00 OKAY, 10 SLVERR.
REQ-016 s_axi_bvalid / s_axi_bready  out / in  1  B handshake.
REQ-017 o_mem_we  out  1  one-cycle memory write strobe.
REQ-018 o_mem_addr  out  log2(MEM_WORDS)  word index.
REQ-019 o_mem_wdata  out  32  write data; o_mem_wstrb  out  4  byte enables.

Function
REQ-020 FSM states: IDLE, DATA, RESP; one outstanding burst only.
REQ-021 IDLE: awready=1, wready=0; on awvalid&awready, latch addr/len/size/burst, clear error flag, clear beat counter, enter DATA next cycle.
REQ-022 DATA: awready=0, wready=1; one beat accepted per cycle with wvalid&wready; wvalid gaps are tolerated.
REQ-023 Beat byte address: start address with bits[1:0] ignored; INCR adds 4 per beat; FIXED holds.
REQ-024 In-range check per beat: MEM_BASE <= addr < MEM_BASE+4*MEM_WORDS, evaluated in ADDR_WIDTH+1 bits (no wrap-around).
REQ-025 Word index = (addr-MEM_BASE)>>2, truncated to log2(MEM_WORDS) bits.
REQ-026 A beat that is in range with legal size/burst drives o_mem_we=1 on the following cycle for exactly one cycle, with that beat's index/data/strb registered (latency 1).
REQ-027 Sticky error set on: illegal awsize; illegal awburst; any out-of-range beat; wlast=1 before the final beat; wlast=0 on the final beat.
REQ-028 With illegal size or burst, all beats are accepted and dropped (no o_mem_we).
REQ-029 An INCR burst running past the window end writes its in-range beats and drops the rest.
REQ-030 Termination is count-based: after beat awlen+1 is accepted, go to RESP; wready=0 from the next cycle, regardless of wlast.
REQ-031 RESP: bvalid=1 and bresp = error ? 2'b10 : 2'b00, held stable until bready; on bvalid&bready, return to IDLE and bvalid=0 next cycle.
REQ-032 o_mem_we=0 whenever no accepted beat is pending; addr/data/strb hold their last value.

Reset
REQ-033 When reset=1 at a clk edge: state=IDLE; awready=0, wready=0, bvalid=0, bresp=00, o_mem_we=0, o_mem_addr/wdata/wstrb=0; awready=1 on the first cycle after release.
REQ-034 Reset mid-burst abandons the burst: no pending write is issued and no B response is sent.

Verification
REQ-035 Reset pulse -> all outputs 0 during reset; awready=1 one cycle after release.
REQ-036 INCR, awaddr=MEM_BASE+0x10, len=3, data 0xA0..0xA3, strb=F, bready=1 -> writes to idx 4,5,6,7 each one cycle after its beat; bresp=00.
REQ-037 FIXED, awaddr=MEM_BASE+0x8, len=1, data 0x11 then 0x22 -> two writes to idx 2; bresp=00.
REQ-038 INCR, len=3, start at idx MEM_WORDS-1 -> one write, three beats dropped, 4 beats consumed, bresp=10.
REQ-039 awburst=2'b10 with len=3 -> no writes, bresp=10; separately, a legal 4-beat INCR with wlast on beat 1 -> all 4 writes done, bresp=10.
REQ-040 wvalid toggling each cycle, bready held low 5 cycles -> bvalid/bresp stable, awready=0 until the B handshake, then awready=1.
